// File: rtl/dm_sync_bytelane.sv
// dm_sync_bytelane: byte-addressed, word-organised data memory for the MEM stage.
// WORD/HALF/BYTE loads and stores, a registered one-cycle read response, fault
// flagging for misaligned/out-of-range/NONE accesses, and an optional zero-fill
// sweep after reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-fill sweep, one word per cycle, requests refused
// ST_IDLE | accepting one request per cycle
module dm_sync_bytelane #(
    parameter int DEPTH_WORDS = 2048,
    parameter bit INIT_ZERO   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt;
    logic [31:0]   dm [DEPTH_WORDS];

    logic          accept;
    logic          req_err;
    logic [AW-1:0] widx;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;

    assign accept   = req_valid & req_ready;
    assign widx     = req_addr[AW+1:2];
    assign rd_word  = dm[widx];
    assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};

    // State register and sweep pointer; the pointer wraps to 0 as the sweep ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= INIT_ZERO ? ST_INIT : ST_IDLE;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        init_busy = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (init_cnt == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
        endcase
    end

    // Fault decode plus store lane enables; store data is replicated so every lane sees it.
    always_comb begin
        req_err  = 1'b0;
        byte_en  = 4'b0000;
        wr_lanes = req_wdata;
        case (req_size)
            SZ_WORD: begin
                req_err = (req_addr[1:0] != 2'b00);
                byte_en = 4'b1111;
            end
            SZ_HALF: begin
                req_err  = req_addr[0];
                byte_en  = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en  = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
        if (req_addr[31:2] >= 30'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Lane select and extension of the word read on the accept edge.
    always_comb begin
        ld_data = rd_shift;
        case (req_size)
            SZ_HALF: ld_data = {{16{req_sext & rd_shift[15]}}, rd_shift[15:0]};
            SZ_BYTE: ld_data = {{24{req_sext & rd_shift[7]}}, rd_shift[7:0]};
            default: ld_data = rd_shift;
        endcase
    end

    // Array write port: the zero-fill sweep, or a fault-free store on its lanes.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            dm[init_cnt] <= '0;
        end else if (accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    dm[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Response register; data and error hold between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= req_err;
                rsp_rdata <= (req_err || req_we) ? 32'h0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_dm_sync_bytelane.sv
// Bench for dm_sync_bytelane: directed scenarios plus random traffic checked
// against a byte-array reference model.
module tb_dm_sync_bytelane;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [DEPTH*4];
    logic        exp_err;
    logic [31:0] exp_rdata;

    dm_sync_bytelane #(.DEPTH_WORDS(DEPTH), .INIT_ZERO(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte array, accesses as runs of bytes.
    function automatic void model(input logic we, input logic [1:0] size, input logic sext,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int nb;
        logic [31:0] v;
        nb = (size == 2'd1) ? 4 : (size == 2'd2) ? 2 : (size == 2'd3) ? 1 : 0;
        rdata = 32'h0;
        if (nb == 0) err = 1'b1;
        else err = ((addr / 4) >= DEPTH) || ((addr % nb) != 0);
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[addr + i];
            if (sext && nb < 4 && v[8*nb-1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rdata = v;
        end
    endfunction

    // One clock of traffic: drive, advance, compare the response outputs.
    task automatic step(input logic v, input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic e;
        logic [31:0] r;
        req_valid = v;
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        if (v) begin
            chk("req_ready", req_ready, 32'd1);
            model(we, size, sext, addr, wdata, e, r);
            exp_err   = e;
            exp_rdata = r;
        end
        @(posedge clock);
        #1;
        chk($sformatf("rsp_valid@%h", addr), rsp_valid, v);
        chk($sformatf("rsp_err@%h", addr), rsp_err, exp_err);
        chk($sformatf("rsp_rdata@%h", addr), rsp_rdata, exp_rdata);
    endtask

    // Count cycles of the sweep from release; requests offered meanwhile must be refused.
    task automatic watch_init(input string tag);
        int busy = 0;
        int bad_ready = 0;
        int bad_valid = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd1;
        req_addr  = 32'h0;
        while (init_busy === 1'b1 && busy < 100) begin
            if (req_ready !== 1'b0) bad_ready++;
            if (rsp_valid !== 1'b0) bad_valid++;
            @(posedge clock);
            #1;
            busy++;
        end
        if (rsp_valid !== 1'b0) bad_valid++;
        req_valid = 1'b0;
        chk({tag, "_busy_cycles"}, busy, DEPTH);
        chk({tag, "_ready_during_init"}, bad_ready, 0);
        chk({tag, "_rsp_valid_during_init"}, bad_valid, 0);
        chk({tag, "_ready_after"}, req_ready, 32'd1);
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        logic        rv, rwe, rsx;
        logic [1:0]  rsz;
        logic [31:0] ra;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_sext  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;

        // Reset held for three cycles, then the sweep.
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rsp_valid", rsp_valid, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", rsp_err, 32'd0);
        chk("reset_init_busy", init_busy, 32'd1);
        chk("reset_req_ready", req_ready, 32'd0);
        reset = 1'b1;
        watch_init("init1");

        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b0, 2'd1, 1'b0, 32'(w*4), 32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // Word store then byte loads with sign and zero extension.
        step(1'b1, 1'b1, 2'd1, 1'b0, 32'h8, 32'hDEADBEEF);
        step(1'b1, 1'b0, 2'd3, 1'b1, 32'hB, 32'h0);
        chk("byte_sext_0xB", rsp_rdata, 32'hFFFFFFDE);
        step(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
        chk("byte_zext_0x8", rsp_rdata, 32'h000000EF);

        // Half store followed immediately by a word load of the same word.
        step(1'b1, 1'b1, 2'd2, 1'b0, 32'hA, 32'h00001234);
        step(1'b1, 1'b0, 2'd1, 1'b0, 32'h8, 32'h0);
        chk("raw_word_0x8", rsp_rdata, 32'h1234BEEF);

        // Faulting accesses leave memory untouched.
        step(1'b1, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
        chk("misaligned_word_err", rsp_err, 32'd1);
        step(1'b1, 1'b1, 2'd2, 1'b0, 32'h3, 32'h0000AAAA);
        chk("misaligned_half_err", rsp_err, 32'd1);
        step(1'b1, 1'b1, 2'd1, 1'b0, 32'(DEPTH*4), 32'h55555555);
        chk("range_store_err", rsp_err, 32'd1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 32'(DEPTH*4), 32'h0);
        step(1'b1, 1'b1, 2'd0, 1'b0, 32'h4, 32'h77777777);
        step(1'b1, 1'b1, 2'd1, 1'b0, 32'h8000_0008, 32'h66666666);
        step(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'd1, 1'b0, 32'h4, 32'h0);
        step(1'b1, 1'b0, 2'd1, 1'b0, 32'h8, 32'h0);
        chk("unchanged_0x8", rsp_rdata, 32'h1234BEEF);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // Eight back-to-back valid requests, then mixed random traffic.
        for (int n = 0; n < 8 + 400; n++) begin
            rv  = (n < 8) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            rwe = 1'($urandom_range(0, 1));
            rsz = (n < 8) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            rsx = 1'($urandom_range(0, 1));
            ra  = (n < 8) ? 32'($urandom_range(0, DEPTH*4 - 1)) : 32'($urandom_range(0, DEPTH*4 + 7));
            if ($urandom_range(0, 3) != 0 || n < 8) begin
                if (rsz == 2'd1) ra[1:0] = 2'b00;
                if (rsz == 2'd2) ra[0] = 1'b0;
            end
            if (n >= 8 && $urandom_range(0, 15) == 0) ra[31] = 1'b1;
            step(rv, rwe, rsz, rsx, ra, $urandom);
        end
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // Reset five cycles into a sweep restarts it from word 0.
        step(1'b1, 1'b1, 2'd1, 1'b0, 32'h14, 32'hCAFEF00D);
        reset = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        #1;
        chk("reset2_rsp_valid", rsp_valid, 32'd0);
        chk("reset2_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("midinit_init_busy", init_busy, 32'd1);
        chk("midinit_rsp_valid", rsp_valid, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        watch_init("init2");
        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b0, 2'd1, 1'b0, 32'(w*4), 32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
